// File: rtl/cpu_board_top.sv
// Board top for the chapter-9 teaching CPU: a prescaler divides pin_clock into a
// slow clock that steps a 4-bit accumulator CPU running from a 16x8 ROM image.

module cpu_board_prescaler #(
    parameter int unsigned RATIO = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slow_clock_o
);

    // Register names are kept plain so benches can reach them hierarchically.
    logic [31:0] counter;
    logic        slow_clock;

    // NOTE: sequential state is assigned with <= so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            slow_clock <= 1'b0;
        end else if (counter == 32'(RATIO - 1)) begin
            counter    <= '0;
            slow_clock <= ~slow_clock;
        end else begin
            counter    <= counter + 32'd1;
        end
    end

    assign slow_clock_o = slow_clock;

endmodule

module cpu_board_top #(
    parameter int unsigned CLOCK_RATIO = 25_000_000,
    // Byte i of the image is ROM address i; the default program blinks the LED.
    parameter logic [127:0] ROM_IMAGE  = 128'h3030_3030_3030_3030_3030_3030_2000_2001
) (
    input  logic pin_clock,
    input  logic pin_n_reset,
    output logic pin_led
);

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_OUT = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JNC = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;

    logic       slow_clock;
    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic       carry_q, carry_d;
    logic [3:0] out_reg_q, out_reg_d;
    logic [7:0] instr;
    logic [3:0] op, imm;
    logic [4:0] sum;
    logic       out_unused;

    cpu_board_prescaler #(
        .RATIO(CLOCK_RATIO)
    ) prescaler (
        .clk         (pin_clock),
        .rst_n       (pin_n_reset),
        .slow_clock_o(slow_clock)
    );

    // The ROM is a constant image read combinationally, so it has no reset.
    assign instr = ROM_IMAGE[{pc_q, 3'b000} +: 8];
    assign op    = instr[7:4];
    assign imm   = instr[3:0];
    assign sum   = {1'b0, a_q} + {1'b0, imm};

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d      = pc_q + 4'd1;
        a_d       = a_q;
        carry_d   = carry_q;
        out_reg_d = out_reg_q;
        case (op)
            OP_MOV: begin
                a_d     = imm;
                carry_d = 1'b0;
            end
            OP_ADD: {carry_d, a_d} = sum;
            OP_OUT: out_reg_d = a_q;
            OP_JMP: pc_d = imm;
            OP_JNC: if (!carry_q) pc_d = imm;
            OP_NOT: a_d = ~a_q;
            default: ;
        endcase
    end

    // The CPU steps on the divided clock; reset stays asynchronous to pin_clock.
    always_ff @(posedge slow_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            pc_q      <= '0;
            a_q       <= '0;
            carry_q   <= 1'b0;
            out_reg_q <= '0;
        end else begin
            pc_q      <= pc_d;
            a_q       <= a_d;
            carry_q   <= carry_d;
            out_reg_q <= out_reg_d;
        end
    end

    assign pin_led    = out_reg_q[0];
    // Upper output bits are architectural state with no pin of their own.
    assign out_unused = ^out_reg_q[3:1];

endmodule

// File: tb/tb_cpu_board_top.sv
// Bench for cpu_board_top: several instances with different ROM images and ratios,
// checked against constant vectors and an instruction-level model of the CPU.

module tb_cpu_board_top;

    localparam logic [127:0] ROM_BLINK = 128'h3030_3030_3030_3030_3030_3030_2000_2001;
    localparam logic [127:0] ROM_ADD   = 128'h6060_6060_6060_6060_6060_6034_2041_110E;
    localparam logic [127:0] ROM_NOT   = 128'h6060_6060_6060_6060_6060_6060_6020_500A;
    localparam logic [127:0] ROM_MIX   = 128'hFF70_2060_2046_1F9F_2019_2050_4120_1507;
    localparam int K_END = 150;

    logic clk;
    logic rst_n, rst_n_rst, rst_n_rnd;
    logic led_main, led_rst, led_add, led_not, led_r5, led_rnd;

    int total = 0;
    int bad   = 0;

    cpu_board_top #(.CLOCK_RATIO(2), .ROM_IMAGE(ROM_BLINK)) u_main (
        .pin_clock(clk), .pin_n_reset(rst_n), .pin_led(led_main));
    cpu_board_top #(.CLOCK_RATIO(2), .ROM_IMAGE(ROM_BLINK)) u_rst (
        .pin_clock(clk), .pin_n_reset(rst_n_rst), .pin_led(led_rst));
    cpu_board_top #(.CLOCK_RATIO(2), .ROM_IMAGE(ROM_ADD)) u_add (
        .pin_clock(clk), .pin_n_reset(rst_n), .pin_led(led_add));
    cpu_board_top #(.CLOCK_RATIO(2), .ROM_IMAGE(ROM_NOT)) u_not (
        .pin_clock(clk), .pin_n_reset(rst_n), .pin_led(led_not));
    cpu_board_top #(.CLOCK_RATIO(5), .ROM_IMAGE(ROM_BLINK)) u_r5 (
        .pin_clock(clk), .pin_n_reset(rst_n), .pin_led(led_r5));
    cpu_board_top #(.CLOCK_RATIO(1), .ROM_IMAGE(ROM_MIX)) u_rnd (
        .pin_clock(clk), .pin_n_reset(rst_n_rnd), .pin_led(led_rnd));

    typedef struct {
        int          k;
        logic [31:0] counter;
        logic        slow;
        logic        led;
        logic [3:0]  pc;
    } vec_t;

    typedef struct {
        int pc;
        int a;
        int carry;
        int out;
    } model_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural interpreter: run n instructions from the reset state.
    function automatic model_t run_cpu(input logic [127:0] rom, input int n);
        model_t m = '{pc: 0, a: 0, carry: 0, out: 0};
        for (int i = 0; i < n; i++) begin
            int op  = int'(rom[8*m.pc+4 +: 4]);
            int imm = int'(rom[8*m.pc +: 4]);
            int nxt = (m.pc + 1) % 16;
            case (op)
                0: begin m.a = imm; m.carry = 0; end
                1: begin m.carry = (m.a + imm > 15) ? 1 : 0; m.a = (m.a + imm) % 16; end
                2: m.out = m.a;
                3: nxt = imm;
                4: if (m.carry == 0) nxt = imm;
                5: m.a = 15 - m.a;
                default: ;
            endcase
            m.pc = nxt;
        end
        return m;
    endfunction

    // k = pin_clock rising edges since reset release.
    task automatic check_model(input string tag, input int k, input int ratio,
                               input logic [127:0] rom, input logic [31:0] counter,
                               input logic slow, input logic [3:0] pc, input logic [3:0] a,
                               input logic carry, input logic [3:0] out, input logic led);
        model_t m = run_cpu(rom, ((k / ratio) + 1) / 2);
        string  s = $sformatf("%s k=%0d", tag, k);
        check({s, " counter"}, counter, 32'(k % ratio));
        check({s, " slow"}, 32'(slow), 32'((k / ratio) % 2));
        check({s, " pc"}, 32'(pc), 32'(m.pc));
        check({s, " a"}, 32'(a), 32'(m.a));
        check({s, " carry"}, 32'(carry), 32'(m.carry));
        check({s, " out"}, 32'(out), 32'(m.out));
        check({s, " led"}, 32'(led), 32'(m.out % 2));
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n     = 1'b0;
        rst_n_rst = 1'b0;
        #10;
        rst_n     = 1'b1;
        rst_n_rst = 1'b1;
        #60;
        rst_n_rst = 1'b0;
        #10;
        rst_n_rst = 1'b1;
    end

    initial begin
        vec_t vecs[$];
        int   rnd_k;
        bit   rnd_in_reset;

        vecs = '{
            '{k: 0,  counter: 0, slow: 0, led: 0, pc: 0},
            '{k: 1,  counter: 1, slow: 0, led: 0, pc: 0},
            '{k: 2,  counter: 0, slow: 1, led: 0, pc: 1},
            '{k: 3,  counter: 1, slow: 1, led: 0, pc: 1},
            '{k: 4,  counter: 0, slow: 0, led: 0, pc: 1},
            '{k: 6,  counter: 0, slow: 1, led: 1, pc: 2},
            '{k: 13, counter: 1, slow: 0, led: 1, pc: 3},
            '{k: 14, counter: 0, slow: 1, led: 0, pc: 4},
            '{k: 18, counter: 0, slow: 1, led: 0, pc: 0},
            '{k: 22, counter: 0, slow: 1, led: 0, pc: 1},
            '{k: 25, counter: 1, slow: 0, led: 0, pc: 1},
            '{k: 26, counter: 0, slow: 1, led: 1, pc: 2}
        };

        rst_n_rnd    = 1'b0;
        rnd_in_reset = 1'b1;
        rnd_k        = 0;

        @(negedge clk);
        #1;
        for (int k = 0; k <= K_END; k++) begin
            // Constant vectors for the blink program at RATIO=2.
            foreach (vecs[i]) begin
                if (vecs[i].k == k) begin
                    check($sformatf("main k=%0d counter", k), u_main.prescaler.counter, vecs[i].counter);
                    check($sformatf("main k=%0d slow", k), 32'(u_main.prescaler.slow_clock), 32'(vecs[i].slow));
                    check($sformatf("main k=%0d led", k), 32'(led_main), 32'(vecs[i].led));
                    check($sformatf("main k=%0d pc", k), 32'(u_main.pc_q), 32'(vecs[i].pc));
                end
            end

            check_model("main", k, 2, ROM_BLINK, u_main.prescaler.counter, u_main.prescaler.slow_clock,
                        u_main.pc_q, u_main.a_q, u_main.carry_q, u_main.out_reg_q, led_main);
            check_model("add", k, 2, ROM_ADD, u_add.prescaler.counter, u_add.prescaler.slow_clock,
                        u_add.pc_q, u_add.a_q, u_add.carry_q, u_add.out_reg_q, led_add);
            check_model("not", k, 2, ROM_NOT, u_not.prescaler.counter, u_not.prescaler.slow_clock,
                        u_not.pc_q, u_not.a_q, u_not.carry_q, u_not.out_reg_q, led_not);
            check_model("r5", k, 5, ROM_BLINK, u_r5.prescaler.counter, u_r5.prescaler.slow_clock,
                        u_r5.pc_q, u_r5.a_q, u_r5.carry_q, u_r5.out_reg_q, led_r5);

            // Mid-run reset: asserted at 70 ns (k=6 sample), released at 80 ns.
            if (k == 6) begin
                check("rst async led", 32'(led_rst), 32'd0);
                check("rst async counter", u_rst.prescaler.counter, 32'd0);
                check("rst async slow", 32'(u_rst.prescaler.slow_clock), 32'd0);
                check("rst async pc", 32'(u_rst.pc_q), 32'd0);
                check("rst async a", 32'(u_rst.a_q), 32'd0);
                check("rst async out", 32'(u_rst.out_reg_q), 32'd0);
            end else begin
                check_model("rst", (k < 6) ? k : k - 7, 2, ROM_BLINK, u_rst.prescaler.counter,
                            u_rst.prescaler.slow_clock, u_rst.pc_q, u_rst.a_q, u_rst.carry_q,
                            u_rst.out_reg_q, led_rst);
            end

            // ADD / carry / JNC: slow edge n lands on k = 4n-2.
            if (k == 6) begin
                check("add e2 a", 32'(u_add.a_q), 32'hF);
                check("add e2 carry", 32'(u_add.carry_q), 32'd0);
            end
            if (k == 10) check("add e3 jnc taken pc", 32'(u_add.pc_q), 32'd1);
            if (k == 14) begin
                check("add e4 a", 32'(u_add.a_q), 32'h0);
                check("add e4 carry", 32'(u_add.carry_q), 32'd1);
            end
            if (k == 18) check("add e5 jnc fall pc", 32'(u_add.pc_q), 32'd3);
            if (k == 22) begin
                check("add e6 out", 32'(u_add.out_reg_q), 32'd0);
                check("add e6 led", 32'(led_add), 32'd0);
            end

            // NOT and pc wrap.
            if (k == 10) begin
                check("not e3 out", 32'(u_not.out_reg_q), 32'd5);
                check("not e3 led", 32'(led_not), 32'd1);
            end
            if (k == 58) check("not e15 pc", 32'(u_not.pc_q), 32'd15);
            if (k == 62) check("not e16 pc wrap", 32'(u_not.pc_q), 32'd0);

            // RATIO=5 slow clock toggles every 5 edges.
            if (k == 4)  check("r5 slow k4", 32'(u_r5.prescaler.slow_clock), 32'd0);
            if (k == 5)  check("r5 slow k5", 32'(u_r5.prescaler.slow_clock), 32'd1);
            if (k == 9)  check("r5 slow k9", 32'(u_r5.prescaler.slow_clock), 32'd1);
            if (k == 10) check("r5 slow k10", 32'(u_r5.prescaler.slow_clock), 32'd0);
            if (k == 15) check("r5 slow k15", 32'(u_r5.prescaler.slow_clock), 32'd1);

            // Random reset pulses on the RATIO=1 mixed program.
            if (rnd_in_reset) begin
                check_model("rnd hold", 0, 1, ROM_MIX, u_rnd.prescaler.counter, u_rnd.prescaler.slow_clock,
                            u_rnd.pc_q, u_rnd.a_q, u_rnd.carry_q, u_rnd.out_reg_q, led_rnd);
                rst_n_rnd    = 1'b1;
                rnd_in_reset = 1'b0;
                rnd_k        = 0;
            end else begin
                rnd_k++;
                check_model("rnd", rnd_k, 1, ROM_MIX, u_rnd.prescaler.counter, u_rnd.prescaler.slow_clock,
                            u_rnd.pc_q, u_rnd.a_q, u_rnd.carry_q, u_rnd.out_reg_q, led_rnd);
                if ($urandom_range(0, 24) == 0) begin
                    rst_n_rnd = 1'b0;
                    #1;
                    check_model("rnd async", 0, 1, ROM_MIX, u_rnd.prescaler.counter,
                                u_rnd.prescaler.slow_clock, u_rnd.pc_q, u_rnd.a_q, u_rnd.carry_q,
                                u_rnd.out_reg_q, led_rnd);
                    rnd_in_reset = 1'b1;
                end
            end

            @(negedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
